// File: rtl/fft_input_framer.sv
// fft_input_framer: collects 8 samples from the upstream serial-to-parallel
// shift stage and presents them to the butterfly stage as one frame in
// bit-reversed index order, using a valid/ready handshake.
//
// Overlap rules:
// - A capture and a transfer may land on the same cycle. In that case the new
//   frame replaces the one being accepted and out_valid stays high.
// - A capture that finds the output still held (valid high, not accepted)
//   drops the new frame and sets the sticky overrun flag.
module fft_input_framer #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic [7:0]       frame_count,
  output logic             overrun
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned FC_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);

  logic [CNT_W-1:0] sample_cnt;
  logic             load_pending;
  logic             transfer_c;
  logic             accept_c;
  logic             drop_c;

  // Handshake decode: transfer, accepted capture, dropped capture.
  always_comb begin
    transfer_c = 1'b0;
    accept_c   = 1'b0;
    drop_c     = 1'b0;
    transfer_c = out_valid & out_ready;
    accept_c   = load_pending & (~out_valid | out_ready);
    drop_c     = load_pending & out_valid & ~out_ready;
  end

  // Sample counter; load_pending flags the cycle after the 8th sample.
  // The upstream taps update on the same edge that sets load_pending.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sample_cnt   <= '0;
      load_pending <= 1'b0;
    end else if (flush) begin
      sample_cnt   <= '0;
      load_pending <= 1'b0;
    end else begin
      if (en) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
      load_pending <= en && (sample_cnt == CNT_LAST);
    end
  end

  // Frame register: bit-reversed capture of the taps, only on an accepted capture.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      y0 <= '0;
      y1 <= '0;
      y2 <= '0;
      y3 <= '0;
      y4 <= '0;
      y5 <= '0;
      y6 <= '0;
      y7 <= '0;
    end else if (accept_c) begin
      y0 <= in1;
      y1 <= in5;
      y2 <= in3;
      y3 <= in7;
      y4 <= in2;
      y5 <= in6;
      y6 <= in4;
      y7 <= in8;
    end
  end

  // Valid flag: set by a capture, cleared by a transfer without a new capture.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
    end else if (transfer_c) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered-frame counter; wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      frame_count <= '0;
    end else if (transfer_c) begin
      frame_count <= frame_count + FC_W'(1);
    end
  end

  // Sticky overrun: a completed frame found the output still held.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if (drop_c) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_input_framer.sv
// Directed self-checking bench for fft_input_framer with an upstream
// 8-deep shift stage model driven by the same en strobe.
module tb_fft_input_framer;

  localparam int unsigned WIDTH = 9;

  logic             clk;
  logic             rstn;
  logic             en;
  logic             flush;
  logic             out_ready;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] tap [8];
  logic             out_valid;
  logic [WIDTH-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0]       frame_count;
  logic             overrun;
  logic [71:0]      yv;

  int errors;
  int checks;
  int cyc;
  int vcount;
  int first_v;
  int last_v;

  fft_input_framer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rstn(rstn), .en(en), .flush(flush),
    .in1(tap[0]), .in2(tap[1]), .in3(tap[2]), .in4(tap[3]),
    .in5(tap[4]), .in6(tap[5]), .in7(tap[6]), .in8(tap[7]),
    .out_ready(out_ready), .out_valid(out_valid),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
    .frame_count(frame_count), .overrun(overrun)
  );

  assign yv = {y0, y1, y2, y3, y4, y5, y6, y7};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream shift stage: tap[0] oldest, tap[7] newest.
  always @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 7; i++) tap[i] <= tap[i+1];
      tap[7] <= sample;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pk(input int a, b, c, d, e, f, g, h);
    return 128'({9'(a), 9'(b), 9'(c), 9'(d), 9'(e), 9'(f), 9'(g), 9'(h)});
  endfunction

  // One clock; observe outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) begin
      vcount++;
      last_v = cyc;
      if (first_v == 0) first_v = cyc;
    end
  endtask

  task automatic clr();
    cyc = 0; vcount = 0; first_v = 0; last_v = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0; flush = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic burst(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      en = 1'b1;
      sample = WIDTH'(start + i);
      tick();
    end
    en = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    for (int i = 0; i < 8; i++) tap[i] = '0;
    sample = '0; out_ready = 1'b0;
    clr();
    do_reset();

    // Reset state
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_y", 128'(yv), 128'(0));
    check("rst_fc", 128'(frame_count), 128'(0));
    check("rst_ovr", 128'(overrun), 128'(0));

    // Single frame, latency and bit reversal
    out_ready = 1'b1;
    burst(8, 1);
    check("f1_not_yet", 128'(out_valid), 128'(0));
    tick();
    check("f1_valid", 128'(out_valid), 128'(1));
    check("f1_y", yv, pk(1, 5, 3, 7, 2, 6, 4, 8));
    check("f1_fc_before", 128'(frame_count), 128'(0));
    tick();
    check("f1_fc_after", 128'(frame_count), 128'(1));
    check("f1_valid_drop", 128'(out_valid), 128'(0));
    check("f1_y_hold", yv, pk(1, 5, 3, 7, 2, 6, 4, 8));

    // Three back-to-back frames
    clr();
    burst(24, 20);
    tick(); tick(); tick();
    check("f3_pulses", 128'(vcount), 128'(3));
    check("f3_first", 128'(first_v), 128'(9));
    check("f3_last", 128'(last_v), 128'(25));
    check("f3_fc", 128'(frame_count), 128'(4));
    check("f3_y", yv, pk(36, 40, 38, 42, 37, 41, 39, 43));
    check("f3_ovr", 128'(overrun), 128'(0));

    // Backpressure: second frame dropped, overrun sticky
    do_reset();
    out_ready = 1'b0;
    burst(16, 1);
    tick();
    check("bp_valid", 128'(out_valid), 128'(1));
    check("bp_y", yv, pk(1, 5, 3, 7, 2, 6, 4, 8));
    check("bp_ovr", 128'(overrun), 128'(1));
    check("bp_fc0", 128'(frame_count), 128'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_fc1", 128'(frame_count), 128'(1));
    check("bp_valid0", 128'(out_valid), 128'(0));
    tick();
    check("bp_y_hold", yv, pk(1, 5, 3, 7, 2, 6, 4, 8));
    check("bp_ovr_sticky", 128'(overrun), 128'(1));

    // Ready rises exactly in the capture cycle
    do_reset();
    out_ready = 1'b0;
    burst(8, 1);
    tick();
    burst(8, 50);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("cc_valid", 128'(out_valid), 128'(1));
    check("cc_y", yv, pk(50, 54, 52, 56, 51, 55, 53, 57));
    check("cc_ovr", 128'(overrun), 128'(0));
    check("cc_fc", 128'(frame_count), 128'(1));

    // Flush (with a coincident en) aborts the partial frame
    do_reset();
    out_ready = 1'b1;
    clr();
    burst(5, 1);
    flush = 1'b1; en = 1'b1; sample = WIDTH'(99);
    tick();
    flush = 1'b0; en = 1'b0;
    burst(8, 10);
    tick(); tick(); tick();
    check("fl_count", 128'(vcount), 128'(1));
    check("fl_first", 128'(first_v), 128'(15));
    check("fl_y", yv, pk(10, 14, 12, 16, 11, 15, 13, 17));
    check("fl_fc", 128'(frame_count), 128'(1));

    // Reset mid-frame clears everything, next 8 en form one frame
    do_reset();
    out_ready = 1'b0;
    burst(22, 1);
    rstn = 1'b0; en = 1'b1; out_ready = 1'b1;
    tick(); tick();
    en = 1'b0;
    check("mr_valid", 128'(out_valid), 128'(0));
    check("mr_y", 128'(yv), 128'(0));
    check("mr_fc", 128'(frame_count), 128'(0));
    check("mr_ovr", 128'(overrun), 128'(0));
    rstn = 1'b1;
    clr();
    burst(8, 60);
    tick(); tick(); tick();
    check("mr_count", 128'(vcount), 128'(1));
    check("mr_first", 128'(first_v), 128'(9));
    check("mr_frame", yv, pk(60, 64, 62, 66, 61, 65, 63, 67));

    // frame_count wraps 255 -> 0 after 256 frames
    do_reset();
    out_ready = 1'b1;
    clr();
    burst(2048, 0);
    tick(); tick();
    check("wrap_pulses", 128'(vcount), 128'(256));
    check("wrap_fc", 128'(frame_count), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
